fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Dual-issue fetch-stage PC generator; sits directly upstream of the 2-bit branch predictor.
- Each cycle it drives the pair PC_inst1_F / PC_inst2_F into the predictor and instruction memory.
- It combines the returned direction predictions with an internal direct-mapped branch target buffer (BTB) to select the next fetch PC.
- A resolved misprediction from Execute redirects it, and Execute also writes the BTB.

Parameters:
- PC_W, 8, PC width in bits (word-addressed instruction memory, +1 per instruction).
- BTB_ENTRIES, 16, number of BTB entries; power of two, 2..64.
- RESET_PC, 8'h00, PC fetched after reset release.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_F  in  1  hold current fetch pair.
- redirect_E  in  1  Execute detected mispredict; squash and refetch.
- redirect_pc_E  in  PC_W  correct PC after mispredict.
- prediction_inst1  in  1  predictor direction for slot 1 (combinational from PC_inst1_F).
- prediction_inst2  in  1  predictor direction for slot 2.
- btb_wr1_E  in  1  BTB write, port 1.
- btb_wr1_pc_E  in  PC_W  branch PC, port 1.
- btb_wr1_tgt_E  in  PC_W  taken target, port 1.
- btb_wr2_E  in  1  BTB write, port 2.
- btb_wr2_pc_E  in  PC_W  branch PC, port 2.
- btb_wr2_tgt_E  in  PC_W  taken target, port 2.
- PC_inst1_F  out  PC_W  slot-1 fetch PC.
- PC_inst2_F  out  PC_W  slot-2 fetch PC.
- inst1_valid_F  out  1  slot 1 carries a real instruction.
- inst2_valid_F  out  1  slot 2 carries a real instruction.
- pred_taken_inst1_F  out  1  slot 1 predicted taken (BPU taken AND BTB hit).
- pred_taken_inst2_F  out  1  slot 2 predicted taken.
- pred_target_F  out  PC_W  chosen predicted target, else 0.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset named reset.
- Reset outputs and state:
  - pc_q <= RESET_PC and all BTB valid bits <= 0.
  - While reset is high: inst*_valid_F = 0, pred_taken_* = 0, pred_target_F = 0.
  - PC outputs follow pc_q, so PC_inst1_F = RESET_PC during reset.
- PC pair: PC_inst1_F = pc_q; PC_inst2_F = pc_q+1 mod 2^PC_W (255 -> 0).
- BTB:
  - Index = pc[IDX-1:0], IDX = log2(BTB_ENTRIES); tag = pc[PC_W-1:IDX].
  - Entry holds valid, tag and target.
  - Two combinational read ports: slot 1 and slot 2.
  - hitN = valid AND tag match.
- Slot predictions:
  - pred_taken_inst1_F = prediction_inst1 & hit1.
  - pred_taken_inst2_F = prediction_inst2 & hit2 & ~pred_taken_inst1_F.
- Valid outputs:
  - inst1_valid_F = ~reset & ~redirect_E.
  - inst2_valid_F = inst1_valid_F & ~pred_taken_inst1_F (slot 2 is dead after a taken slot 1).
- Next-PC priority at each edge:
  1. reset -> RESET_PC.
  2. redirect_E -> redirect_pc_E (overrides stall_F).
  3. stall_F -> hold pc_q.
  4. pred_taken_inst1_F -> target1.
  5. pred_taken_inst2_F -> target2.
  6. otherwise pc_q+2 mod 2^PC_W (254 -> 0, 255 -> 1).
- Latency: redirect is registered, so the first fetch of redirect_pc_E is presented the cycle after redirect_E. The redirect cycle itself is squashed.
- BTB writes:
  - Registered; visible to lookups the next cycle; no write-to-read bypass.
  - Write sets valid, tag and target.
  - Both ports writing the same index in one cycle: port 2 wins.
  - A write is not blocked by stall_F or redirect_E; it is blocked by reset.
- Stall: outputs remain a pure function of held pc_q; predictions may change if the BPU updates during the stall, and next PC reflects the current values.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_redirect_cnt[15:0] and perf_pred_taken_cnt[15:0], both synchronously cleared by reset.
  - perf_redirect_cnt increments once per cycle with redirect_E=1.
  - perf_pred_taken_cnt increments per unstalled, unsquashed cycle with either pred_taken_* = 1.
  - Both counters saturate at 16'hFFFF.
- When undefined: no ports, no counter logic.

Decomposition:
- Package fetch_pkg: PC_W, BTB_ENTRIES default, IDX width, tag width, btb_entry_t struct {valid, tag, target}, RESET_PC default.
- One sub-module: fetch_btb (dual read port, dual write port, port-2 priority, synchronous valid clear).
- The PC register and next-PC mux stay in fetch_pc_unit.

Test Plan:
- Reset and sequential fetch: reset high 2 cycles, then low with no hits -> PC_inst1_F = 0, 2, 4, …; PC_inst2_F = 1, 3, 5; both valids = 1.
- Wrap-around: redirect to 8'hFE, then 8'hFF -> pairs (FE, FF) then next 00; redirect to FF -> pair (FF, 00), next pc 01.
- Slot-1 taken: BTB write pc=0x10 tgt=0x40; fetch 0x10 with prediction_inst1=1 -> pred_taken_inst1_F=1, inst2_valid_F=0, pred_target_F=0x40, next pc 0x40.
- Slot-2 taken and BTB miss:
  - BTB pc=0x21 tgt=0x05 at fetch 0x20 with prediction_inst2=1 -> next 0x05.
  - Same fetch with an empty BTB -> pred_taken=0, next 0x22.
- Redirect vs stall: stall_F=1 and redirect_E=1 with redirect_pc_E=0x80 -> valids 0 that cycle, next PC_inst1_F = 0x80.
- Same-index double write: both ports write index 3 (pc 0x03 tgt 0x11, pc 0x13 tgt 0x22) -> lookup of 0x13 hits with 0x22; lookup of 0x03 misses.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the dual-issue fetch PC unit.
package fetch_pkg;

  localparam int PC_W             = 8;
  localparam int DEF_BTB_ENTRIES  = 16;
  localparam int DEF_BTB_IDX_W    = $clog2(DEF_BTB_ENTRIES);
  localparam int DEF_BTB_TAG_W    = PC_W - DEF_BTB_IDX_W;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 8'h00;

  // The tag field is PC_W-1 bits wide so one entry type fits every legal
  // BTB size (the index is at least one bit). Unused upper bits stay zero.
  typedef struct packed {
    logic            valid;
    logic [PC_W-2:0] tag;
    logic [PC_W-1:0] target;
  } btb_entry_t;

  // Tag of a PC for a BTB with idxW index bits, zero-extended to the field.
  function automatic logic [PC_W-2:0] btb_tag(input logic [PC_W-1:0] pc,
                                              input int idxW);
    logic [PC_W-1:0] shifted;
    shifted = pc >> idxW;
    return shifted[PC_W-2:0];
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: Execute redirect/BTB-write inputs, predictor directions,
// and the fetch pair presented to the predictor and instruction memory.
interface fetch_pc_unit_if;
  import fetch_pkg::*;

  logic            stall_F;
  logic            redirect_E;
  logic [PC_W-1:0] redirect_pc_E;
  logic            prediction_inst1;
  logic            prediction_inst2;
  logic            btb_wr1_E;
  logic [PC_W-1:0] btb_wr1_pc_E;
  logic [PC_W-1:0] btb_wr1_tgt_E;
  logic            btb_wr2_E;
  logic [PC_W-1:0] btb_wr2_pc_E;
  logic [PC_W-1:0] btb_wr2_tgt_E;
  logic [PC_W-1:0] PC_inst1_F;
  logic [PC_W-1:0] PC_inst2_F;
  logic            inst1_valid_F;
  logic            inst2_valid_F;
  logic            pred_taken_inst1_F;
  logic            pred_taken_inst2_F;
  logic [PC_W-1:0] pred_target_F;

  // The fetch unit itself.
  modport master (
    input  stall_F, redirect_E, redirect_pc_E,
    input  prediction_inst1, prediction_inst2,
    input  btb_wr1_E, btb_wr1_pc_E, btb_wr1_tgt_E,
    input  btb_wr2_E, btb_wr2_pc_E, btb_wr2_tgt_E,
    output PC_inst1_F, PC_inst2_F, inst1_valid_F, inst2_valid_F,
    output pred_taken_inst1_F, pred_taken_inst2_F, pred_target_F
  );

  // The surrounding pipeline (predictor, Execute).
  modport slave (
    output stall_F, redirect_E, redirect_pc_E,
    output prediction_inst1, prediction_inst2,
    output btb_wr1_E, btb_wr1_pc_E, btb_wr1_tgt_E,
    output btb_wr2_E, btb_wr2_pc_E, btb_wr2_tgt_E,
    input  PC_inst1_F, PC_inst2_F, inst1_valid_F, inst2_valid_F,
    input  pred_taken_inst1_F, pred_taken_inst2_F, pred_target_F
  );

endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: two combinational read ports, two
// registered write ports (port 2 wins on an index collision).
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = DEF_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd1_pc_i,
  input  logic [PC_W-1:0] rd2_pc_i,
  output logic            hit1_o,
  output logic            hit2_o,
  output logic [PC_W-1:0] tgt1_o,
  output logic [PC_W-1:0] tgt2_o,
  input  logic            wr1_i,
  input  logic [PC_W-1:0] wr1_pc_i,
  input  logic [PC_W-1:0] wr1_tgt_i,
  input  logic            wr2_i,
  input  logic [PC_W-1:0] wr2_pc_i,
  input  logic [PC_W-1:0] wr2_tgt_i
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t     mem_q [BTB_ENTRIES];
  btb_entry_t     rd1_entry, rd2_entry;
  btb_entry_t     wr1_entry, wr2_entry;
  logic [IDX-1:0] rd1_idx, rd2_idx, wr1_idx, wr2_idx;

  // Lookup both fetch slots and build the entries Execute wants to store.
  always_comb begin
    rd1_idx   = rd1_pc_i[IDX-1:0];
    rd2_idx   = rd2_pc_i[IDX-1:0];
    wr1_idx   = wr1_pc_i[IDX-1:0];
    wr2_idx   = wr2_pc_i[IDX-1:0];
    rd1_entry = mem_q[rd1_idx];
    rd2_entry = mem_q[rd2_idx];
    hit1_o    = rd1_entry.valid && (rd1_entry.tag == btb_tag(rd1_pc_i, IDX));
    hit2_o    = rd2_entry.valid && (rd2_entry.tag == btb_tag(rd2_pc_i, IDX));
    tgt1_o    = rd1_entry.target;
    tgt2_o    = rd2_entry.target;
    wr1_entry = '{valid: 1'b1, tag: btb_tag(wr1_pc_i, IDX), target: wr1_tgt_i};
    wr2_entry = '{valid: 1'b1, tag: btb_tag(wr2_pc_i, IDX), target: wr2_tgt_i};
  end

  // Reset only invalidates entries; port 2 is written last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else begin
      if (wr1_i) mem_q[wr1_idx] <= wr1_entry;
      if (wr2_i) mem_q[wr2_idx] <= wr2_entry;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Dual-issue fetch PC generator: PC register, BTB-backed next-PC selection
// and Execute redirect. Define FETCH_PERF_CNT_EN to add saturating
// redirect / predicted-taken event counters.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              BTB_ENTRIES = DEF_BTB_ENTRIES,
  parameter logic [PC_W-1:0] RESET_PC    = DEF_RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  fetch_pc_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   perf_redirect_cnt,
  output logic [15:0]   perf_pred_taken_cnt
`endif
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus1, pc_plus2;
  logic            hit1, hit2;
  logic [PC_W-1:0] tgt1, tgt2;
  logic            pred1, pred2;

  fetch_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd1_pc_i  (pc_q),
    .rd2_pc_i  (pc_plus1),
    .hit1_o    (hit1),
    .hit2_o    (hit2),
    .tgt1_o    (tgt1),
    .tgt2_o    (tgt2),
    .wr1_i     (bus.btb_wr1_E),
    .wr1_pc_i  (bus.btb_wr1_pc_E),
    .wr1_tgt_i (bus.btb_wr1_tgt_E),
    .wr2_i     (bus.btb_wr2_E),
    .wr2_pc_i  (bus.btb_wr2_pc_E),
    .wr2_tgt_i (bus.btb_wr2_tgt_E)
  );

  // Fetch pair, slot predictions and the next-PC priority mux.
  always_comb begin
    pc_plus1 = pc_q + PC_W'(1);
    pc_plus2 = pc_q + PC_W'(2);
    pred1    = ~reset & bus.prediction_inst1 & hit1;
    pred2    = ~reset & bus.prediction_inst2 & hit2 & ~pred1;

    bus.PC_inst1_F         = pc_q;
    bus.PC_inst2_F         = pc_plus1;
    bus.pred_taken_inst1_F = pred1;
    bus.pred_taken_inst2_F = pred2;
    bus.inst1_valid_F      = ~reset & ~bus.redirect_E;
    bus.inst2_valid_F      = ~reset & ~bus.redirect_E & ~pred1;
    bus.pred_target_F      = pred1 ? tgt1 : (pred2 ? tgt2 : '0);

    pc_d = pc_plus2;
    if (bus.redirect_E)   pc_d = bus.redirect_pc_E;
    else if (bus.stall_F) pc_d = pc_q;
    else if (pred1)       pc_d = tgt1;
    else if (pred2)       pc_d = tgt2;
  end

  // PC register; reset has top priority over every redirect or stall.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redir_cnt_q, taken_cnt_q;

  // Saturating event counters; a squashed or stalled cycle is not a taken fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      redir_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (bus.redirect_E && redir_cnt_q != 16'hFFFF)
        redir_cnt_q <= redir_cnt_q + 16'd1;
      if (~bus.stall_F && ~bus.redirect_E && (pred1 | pred2) && taken_cnt_q != 16'hFFFF)
        taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign perf_redirect_cnt   = redir_cnt_q;
  assign perf_pred_taken_cnt = taken_cnt_q;
`endif

endmodule
